// File: rtl/ibex_obi_arb_pkg.sv
// Shared types and helpers for the OBI arbiter and its in-order ID FIFO.
package ibex_obi_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Width needed to index num entries; never narrower than one bit.
  function automatic int idx_width(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

  // Width needed to hold a count from 0 up to and including depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ibex_obi_arb_id_fifo.sv
// In-order FIFO of host indices for granted transactions awaiting a response.
module ibex_obi_arb_id_fifo
  import ibex_obi_arb_pkg::*;
#(
  parameter int Depth = 2,
  parameter int Width = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push,
  input  logic                        pop,
  input  logic [Width-1:0]            wdata,
  output logic [Width-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(Depth+1)-1:0]  count
);

  localparam int PtrW = idx_width(Depth);
  localparam int CntW = cnt_width(Depth);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    if (ptr == LastPtr) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  // Next storage, pointers and occupancy from this cycle's push/pop.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (pop_ok) begin
      rptr_d = ptr_inc(rptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO registers; reset drops every queued entry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/ibex_obi_arbiter.sv
// Round-robin OBI arbiter: many hosts share one memory port, responses are
// routed back in order via an ID FIFO.
module ibex_obi_arbiter
  import ibex_obi_arb_pkg::*;
#(
  parameter int NumPorts       = 2,
  parameter int MaxOutstanding = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumPorts-1:0]               host_req_i,
  input  logic [NumPorts-1:0]               host_we_i,
  input  logic [NumPorts*(DataWidth/8)-1:0] host_be_i,
  input  logic [NumPorts*AddrWidth-1:0]     host_addr_i,
  input  logic [NumPorts*DataWidth-1:0]     host_wdata_i,
  output logic [NumPorts-1:0]               host_gnt_o,
  output logic [NumPorts-1:0]               host_rvalid_o,
  output logic [DataWidth-1:0]              host_rdata_o,
  output logic                              mem_req_o,
  output logic                              mem_we_o,
  output logic [DataWidth/8-1:0]            mem_be_o,
  output logic [AddrWidth-1:0]              mem_addr_o,
  output logic [DataWidth-1:0]              mem_wdata_o,
  input  logic                              mem_gnt_i,
  input  logic                              mem_rvalid_i,
  input  logic [DataWidth-1:0]              mem_rdata_i,
  output logic                              err_unexpected_o
);

  localparam int BeW  = DataWidth / 8;
  localparam int IdxW = idx_width(NumPorts);
  localparam int CntW = cnt_width(MaxOutstanding);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumPorts - 1);

  arb_state_e       state_q, state_d;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]  lock_idx_q, lock_idx_d;
  logic             err_q, err_d;

  logic [IdxW-1:0]  arb_idx;
  logic             arb_found;
  logic [IdxW-1:0]  cand;
  logic [IdxW-1:0]  sel_idx;
  logic             sel_req;
  logic             sel_we;
  logic [BeW-1:0]   sel_be;
  logic [AddrWidth-1:0] sel_addr;
  logic [DataWidth-1:0] sel_wdata;
  logic             capacity_ok;
  logic             handshake;
  logic             resp_ok;

  logic [IdxW-1:0]  fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CntW-1:0]  fifo_count;
  logic             unused_fifo_full;

  assign unused_fifo_full = fifo_full;

  // Round-robin search: first requester after the last granted host.
  always_comb begin
    arb_idx   = rr_ptr_q;
    arb_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NumPorts; k++) begin
      cand = IdxW'((int'(rr_ptr_q) + k) % NumPorts);
      if (!arb_found && host_req_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // While waiting for a grant the selection is frozen so the payload holds.
  assign sel_idx = (state_q == LOCK) ? lock_idx_q : arb_idx;

  // Multiplex the selected host's request and payload onto the memory side.
  always_comb begin
    sel_req   = 1'b0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (sel_idx == IdxW'(i)) begin
        sel_req   = host_req_i[i];
        sel_we    = host_we_i[i];
        sel_be    = host_be_i[i*BeW +: BeW];
        sel_addr  = host_addr_i[i*AddrWidth +: AddrWidth];
        sel_wdata = host_wdata_i[i*DataWidth +: DataWidth];
      end
    end
  end

  // A response this cycle frees a slot, so a full FIFO can still accept.
  assign capacity_ok  = (fifo_count < MaxCnt) | mem_rvalid_i;
  assign mem_req_o    = rst_ni & sel_req & capacity_ok;
  assign mem_we_o     = sel_we;
  assign mem_be_o     = sel_be;
  assign mem_addr_o   = sel_addr;
  assign mem_wdata_o  = sel_wdata;
  assign handshake    = mem_req_o & mem_gnt_i;
  assign resp_ok      = rst_ni & mem_rvalid_i & ~fifo_empty;
  assign host_rdata_o = mem_rdata_i;
  assign err_unexpected_o = err_q;

  // Grant goes only to the selected host; response goes to the oldest ID.
  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    for (int i = 0; i < NumPorts; i++) begin
      host_gnt_o[i]    = handshake & (sel_idx == IdxW'(i));
      host_rvalid_o[i] = resp_ok & (fifo_head == IdxW'(i));
    end
  end

  ibex_obi_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (handshake),
    .pop    (resp_ok),
    .wdata  (sel_idx),
    .rdata  (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Next state, lock index, round-robin pointer and sticky error flag.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    err_d      = err_q | (mem_rvalid_i & fifo_empty);
    case (state_q)
      ARB: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d    = LOCK;
          lock_idx_d = sel_idx;
        end
      end
      LOCK: begin
        if (mem_gnt_i) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    if (handshake) begin
      rr_ptr_d = sel_idx;
    end
  end

  // Arbiter registers; reset leaves host 0 with first priority.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ARB;
      rr_ptr_q   <= LastIdx;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ibex_obi_arbiter.sv
// Self-checking bench for ibex_obi_arbiter: directed scenarios plus random
// traffic, all compared against a queue-based transaction model.
module tb_ibex_obi_arbiter;

  localparam int NP   = 3;
  localparam int MAXO = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     host_req;
  logic [NP-1:0]     host_we;
  logic [NP*BW-1:0]  host_be;
  logic [NP*AW-1:0]  host_addr;
  logic [NP*DW-1:0]  host_wdata;
  logic [NP-1:0]     host_gnt;
  logic [NP-1:0]     host_rvalid;
  logic [DW-1:0]     host_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [BW-1:0]     mem_be;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DW-1:0]     mem_rdata;
  logic              err_unexpected;

  ibex_obi_arbiter #(
    .NumPorts       (NP),
    .MaxOutstanding (MAXO),
    .AddrWidth      (AW),
    .DataWidth      (DW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .host_req_i       (host_req),
    .host_we_i        (host_we),
    .host_be_i        (host_be),
    .host_addr_i      (host_addr),
    .host_wdata_i     (host_wdata),
    .host_gnt_o       (host_gnt),
    .host_rvalid_o    (host_rvalid),
    .host_rdata_o     (host_rdata),
    .mem_req_o        (mem_req),
    .mem_we_o         (mem_we),
    .mem_be_o         (mem_be),
    .mem_addr_o       (mem_addr),
    .mem_wdata_o      (mem_wdata),
    .mem_gnt_i        (mem_gnt),
    .mem_rvalid_i     (mem_rvalid),
    .mem_rdata_i      (mem_rdata),
    .err_unexpected_o (err_unexpected)
  );

  always #5 clk = ~clk;

  // Per-host payload presented on the next applied cycle.
  logic [AW-1:0] h_addr  [NP];
  logic          h_we    [NP];
  logic [BW-1:0] h_be    [NP];
  logic [DW-1:0] h_wdata [NP];

  // Transaction-level model: queue of hosts awaiting responses.
  int q[$];
  int rr;
  int lockh;
  bit err_m;

  logic [NP-1:0] obs_gnt;
  logic [NP-1:0] obs_rv;
  logic          obs_req;
  logic          obs_err;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_rdata;
  logic [NP-1:0] last_gnt_m;

  int tests;
  int fails;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    rr    = NP - 1;
    lockh = -1;
    err_m = 1'b0;
  endtask

  // Drive one cycle, check outputs mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input logic rst_v, input logic [NP-1:0] req,
                               input logic gnt, input logic rv, input logic [DW-1:0] rdata);
    int sel;
    int c;
    logic exp_req;
    logic [NP-1:0] exp_gnt;
    logic [NP-1:0] exp_rv;
    rst_n      = rst_v;
    host_req   = req;
    mem_gnt    = gnt;
    mem_rvalid = rv;
    mem_rdata  = rdata;
    for (int i = 0; i < NP; i++) begin
      host_addr[i*AW +: AW]  = h_addr[i];
      host_we[i]             = h_we[i];
      host_be[i*BW +: BW]    = h_be[i];
      host_wdata[i*DW +: DW] = h_wdata[i];
    end
    #4;
    sel = -1;
    if (lockh >= 0) begin
      sel = lockh;
    end else begin
      for (int k = 1; k <= NP; k++) begin
        c = (rr + k) % NP;
        if (sel < 0 && req[c]) sel = c;
      end
    end
    exp_req = rst_v && (sel >= 0) && req[sel] && ((q.size() < MAXO) || rv);
    exp_gnt = '0;
    if (exp_req && gnt) exp_gnt[sel] = 1'b1;
    exp_rv = '0;
    if (rst_v && rv && q.size() > 0) exp_rv[q[0]] = 1'b1;

    obs_gnt   = host_gnt;
    obs_rv    = host_rvalid;
    obs_req   = mem_req;
    obs_err   = err_unexpected;
    obs_addr  = mem_addr;
    obs_rdata = host_rdata;

    checkOutput("mem_req", 64'(mem_req), 64'(exp_req));
    checkOutput("host_gnt", 64'(host_gnt), 64'(exp_gnt));
    checkOutput("host_rvalid", 64'(host_rvalid), 64'(exp_rv));
    checkOutput("host_rdata", 64'(host_rdata), 64'(rdata));
    checkOutput("err", 64'(err_unexpected), 64'(err_m));
    if (exp_req) begin
      checkOutput("mem_addr", 64'(mem_addr), 64'(h_addr[sel]));
      checkOutput("mem_we", 64'(mem_we), 64'(h_we[sel]));
      checkOutput("mem_be", 64'(mem_be), 64'(h_be[sel]));
      checkOutput("mem_wdata", 64'(mem_wdata), 64'(h_wdata[sel]));
    end
    last_gnt_m = exp_gnt;

    @(posedge clk);
    if (!rst_v) begin
      modelReset();
    end else begin
      if (rv) begin
        if (q.size() > 0) void'(q.pop_front());
        else err_m = 1'b1;
      end
      if (exp_req && gnt) begin
        q.push_back(sel);
        rr = sel;
      end
      if (gnt) lockh = -1;
      else if (exp_req) lockh = sel;
    end
    #1;
  endtask

  task automatic resetCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  logic [NP-1:0] alt [4];
  logic [NP-1:0] cur_req;
  logic          r_rst, r_gnt, r_rv;

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < NP; i++) begin
      h_addr[i]  = AW'(32'h1000 * (i + 1));
      h_we[i]    = 1'b0;
      h_be[i]    = '1;
      h_wdata[i] = DW'(32'hD000 + i);
    end
    rst_n = 1'b0; host_req = '0; host_we = '0; host_be = '0; host_addr = '0;
    host_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    last_gnt_m = '0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    // Reset state: idle, no error.
    applyStimulus(1'b1, '0, 1'b0, 1'b0, '0);
    checkOutput("rst_req", 64'(obs_req), 64'h0);
    checkOutput("rst_err", 64'(obs_err), 64'h0);

    // Contention between hosts 0 and 1, 1-cycle responses.
    alt = '{3'b001, 3'b010, 3'b001, 3'b010};
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b1, 3'b011, 1'b1, (j > 0), DW'($urandom));
      checkOutput("rr_alt", 64'(obs_gnt), 64'(alt[j]));
    end
    applyStimulus(1'b1, '0, 1'b0, 1'b1, '0);
    resetCycle();

    // Lock: host 0 waits for a grant while host 1 starts requesting.
    h_addr[0] = 32'h100;
    h_addr[1] = 32'h200;
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b1, (j == 0) ? 3'b001 : 3'b011, 1'b0, 1'b0, '0);
      checkOutput("lock_addr", 64'(obs_addr), 64'h100);
      checkOutput("lock_nognt", 64'(obs_gnt), 64'h0);
    end
    applyStimulus(1'b1, 3'b011, 1'b1, 1'b0, '0);
    checkOutput("lock_gnt0", 64'(obs_gnt), 64'b001);
    checkOutput("lock_addr0", 64'(obs_addr), 64'h100);
    applyStimulus(1'b1, 3'b010, 1'b1, 1'b0, '0);
    checkOutput("lock_gnt1", 64'(obs_gnt), 64'b010);
    checkOutput("lock_addr1", 64'(obs_addr), 64'h200);
    repeat (2) applyStimulus(1'b1, '0, 1'b0, 1'b1, '0);
    resetCycle();

    // Capacity limit of two outstanding transactions.
    repeat (2) begin
      applyStimulus(1'b1, 3'b001, 1'b1, 1'b0, '0);
      checkOutput("cap_gnt", 64'(obs_gnt), 64'b001);
    end
    applyStimulus(1'b1, 3'b001, 1'b1, 1'b0, '0);
    checkOutput("cap_block_req", 64'(obs_req), 64'h0);
    checkOutput("cap_block_gnt", 64'(obs_gnt), 64'h0);
    applyStimulus(1'b1, 3'b001, 1'b1, 1'b1, 32'h77);
    checkOutput("cap_rv_req", 64'(obs_req), 64'h1);
    checkOutput("cap_rv_gnt", 64'(obs_gnt), 64'b001);
    checkOutput("cap_rv_rv", 64'(obs_rv), 64'b001);
    repeat (2) applyStimulus(1'b1, '0, 1'b0, 1'b1, '0);
    resetCycle();

    // In-order routing of responses to hosts 1, 0, 1.
    applyStimulus(1'b1, 3'b010, 1'b1, 1'b0, '0);
    checkOutput("ord_g1", 64'(obs_gnt), 64'b010);
    applyStimulus(1'b1, 3'b001, 1'b1, 1'b0, '0);
    checkOutput("ord_g0", 64'(obs_gnt), 64'b001);
    applyStimulus(1'b1, 3'b010, 1'b1, 1'b1, 32'hA);
    checkOutput("ord_g2", 64'(obs_gnt), 64'b010);
    checkOutput("ord_rvA", 64'(obs_rv), 64'b010);
    checkOutput("ord_dA", 64'(obs_rdata), 64'hA);
    applyStimulus(1'b1, '0, 1'b0, 1'b1, 32'hB);
    checkOutput("ord_rvB", 64'(obs_rv), 64'b001);
    checkOutput("ord_dB", 64'(obs_rdata), 64'hB);
    applyStimulus(1'b1, '0, 1'b0, 1'b1, 32'hC);
    checkOutput("ord_rvC", 64'(obs_rv), 64'b010);
    checkOutput("ord_dC", 64'(obs_rdata), 64'hC);
    resetCycle();

    // Unexpected response sets a sticky error until reset.
    applyStimulus(1'b1, '0, 1'b0, 1'b1, 32'h55);
    checkOutput("unexp_rv", 64'(obs_rv), 64'h0);
    checkOutput("unexp_err_now", 64'(obs_err), 64'h0);
    repeat (3) begin
      applyStimulus(1'b1, '0, 1'b0, 1'b0, '0);
      checkOutput("unexp_sticky", 64'(obs_err), 64'h1);
    end
    resetCycle();
    applyStimulus(1'b1, '0, 1'b0, 1'b0, '0);
    checkOutput("unexp_cleared", 64'(obs_err), 64'h0);

    // Reset with two outstanding transactions.
    repeat (2) applyStimulus(1'b1, 3'b001, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 3'b011, 1'b1, 1'b0, '0);
    checkOutput("rstmid_req", 64'(obs_req), 64'h0);
    checkOutput("rstmid_gnt", 64'(obs_gnt), 64'h0);
    applyStimulus(1'b1, '0, 1'b0, 1'b1, 32'h99);
    checkOutput("rstmid_stray", 64'(obs_rv), 64'h0);
    applyStimulus(1'b1, 3'b011, 1'b1, 1'b0, '0);
    checkOutput("rstmid_first", 64'(obs_gnt), 64'b001);
    checkOutput("rstmid_err", 64'(obs_err), 64'h1);
    applyStimulus(1'b1, 3'b011, 1'b1, 1'b0, '0);
    checkOutput("rstmid_second", 64'(obs_gnt), 64'b010);
    applyStimulus(1'b1, 3'b011, 1'b1, 1'b0, '0);
    checkOutput("rstmid_full", 64'(obs_req), 64'h0);
    repeat (2) applyStimulus(1'b1, '0, 1'b0, 1'b1, '0);
    resetCycle();

    // Random traffic; a waiting host keeps its request and payload.
    cur_req = '0;
    last_gnt_m = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NP; i++) begin
        if (!(cur_req[i] && !last_gnt_m[i])) begin
          cur_req[i] = 1'($urandom_range(0, 1));
          h_addr[i]  = AW'($urandom);
          h_we[i]    = 1'($urandom);
          h_be[i]    = BW'($urandom);
          h_wdata[i] = DW'($urandom);
        end
      end
      r_rst = ($urandom_range(0, 99) != 0);
      r_gnt = ($urandom_range(0, 99) < 70);
      if (q.size() > 0) r_rv = ($urandom_range(0, 99) < 45);
      else r_rv = ($urandom_range(0, 99) < 4);
      applyStimulus(r_rst, cur_req, r_gnt, r_rv, DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
